// File: rtl/rf_ddr_delay_sched_if.sv
// Burst command channel between the delay-line scheduler (master) and the DDR AXI engine (slave).
// Latency: command accepted on the cycle cmd_valid && cmd_ready; completion is a one-cycle cmd_done pulse.
// Backpressure: the engine holds cmd_ready low to stall; the master keeps the command stable until accepted.
interface rf_ddr_delay_sched_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_len;
    logic                  cmd_done;
    logic                  cmd_error;

    modport master (
        output cmd_valid,
        output cmd_write,
        output cmd_addr,
        output cmd_len,
        input  cmd_ready,
        input  cmd_done,
        input  cmd_error
    );

    modport slave (
        input  cmd_valid,
        input  cmd_write,
        input  cmd_addr,
        input  cmd_len,
        output cmd_ready,
        output cmd_done,
        output cmd_error
    );
endinterface

// File: rtl/rf_ddr_delay_sched.sv
// Write/read burst scheduler for the DDR ring-buffer delay line; owns ring pointers, fill and arbitration.
// Latency: grant to cmd_valid is 1 cycle; one burst outstanding at a time, next arbitration after cmd_done.
// Backpressure: cmd_valid holds with stable write/addr while cmd_ready is low; commands are never withdrawn.
module rf_ddr_delay_sched #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h1000_0000),
    parameter int                    RING_LOG2   = 18,
    parameter int                    BURST_BEATS = 16,
    parameter int                    BEAT_BYTES  = 4,
    parameter int                    LEVEL_WIDTH = 10
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   enable,
    input  logic [RING_LOG2-1:0]   delay_bursts,
    input  logic [LEVEL_WIDTH-1:0] in_level,
    input  logic [LEVEL_WIDTH-1:0] out_space,
    rf_ddr_delay_sched_if.master   cmd,
    output logic                   busy,
    output logic [RING_LOG2:0]     fill,
    output logic                   overflow,
    output logic                   error
);

    localparam logic [RING_LOG2:0]     FILL_FULL   = {1'b1, {RING_LOG2{1'b0}}};
    localparam logic [LEVEL_WIDTH-1:0] BEATS_LVL   = LEVEL_WIDTH'(BURST_BEATS);
    localparam logic [ADDR_WIDTH-1:0]  BURST_BYTES = ADDR_WIDTH'(BURST_BEATS * BEAT_BYTES);
    localparam logic [7:0]             AXI_LEN     = 8'(BURST_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_e;

    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } grant_e;

    state_e                  state_q, state_d;
    logic [RING_LOG2-1:0]    wr_ptr_q, wr_ptr_d;
    logic [RING_LOG2-1:0]    rd_ptr_q, rd_ptr_d;
    logic [RING_LOG2:0]      fill_q, fill_d;
    logic [RING_LOG2-1:0]    dly_q, dly_d;
    logic                    overflow_q, overflow_d;
    logic                    error_q, error_d;
    logic                    cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    grant_e                  last_grant_q, last_grant_d;

    logic                    in_rdy;
    logic                    wr_ok;
    logic                    rd_ok;
    logic                    grant_wr;
    logic [RING_LOG2-1:0]    grant_ptr;

    // A read is only eligible once more than dly bursts sit in the ring, giving the programmed delay.
    always_comb begin
        in_rdy    = (in_level >= BEATS_LVL);
        wr_ok     = in_rdy && (fill_q < FILL_FULL);
        rd_ok     = (out_space >= BEATS_LVL) && (fill_q > {1'b0, dly_q});
        grant_wr  = wr_ok && (!rd_ok || (last_grant_q == GNT_READ));
        grant_ptr = grant_wr ? wr_ptr_q : rd_ptr_q;
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_d       = fill_q;
        dly_d        = dly_q;
        overflow_d   = overflow_q;
        error_d      = error_q;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        last_grant_d = last_grant_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    // delay_bursts is RING_LOG2 bits, so it can never exceed RING_BURSTS-1.
                    dly_d      = delay_bursts;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    fill_d     = '0;
                    overflow_d = 1'b0;
                    error_d    = 1'b0;
                    state_d    = S_ARB;
                end
            end

            S_ARB: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    if (in_rdy && (fill_q == FILL_FULL)) begin
                        overflow_d = 1'b1;
                    end
                    if (wr_ok || rd_ok) begin
                        cmd_write_d  = grant_wr;
                        cmd_addr_d   = BASE_ADDR + ADDR_WIDTH'(grant_ptr) * BURST_BYTES;
                        last_grant_d = grant_wr ? GNT_WRITE : GNT_READ;
                        state_d      = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (cmd.cmd_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (cmd.cmd_done) begin
                    if (cmd.cmd_error) begin
                        error_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        if (cmd_write_q) begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            fill_d   = fill_q + 1'b1;
                        end else begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                            fill_d   = fill_q - 1'b1;
                        end
                        state_d = S_ARB;
                    end
                end
            end

            S_HALT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            dly_q        <= '0;
            overflow_q   <= 1'b0;
            error_q      <= 1'b0;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= BASE_ADDR;
            last_grant_q <= GNT_READ;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            dly_q        <= dly_d;
            overflow_q   <= overflow_d;
            error_q      <= error_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign cmd.cmd_valid = (state_q == S_ISSUE);
    assign cmd.cmd_write = cmd_write_q;
    assign cmd.cmd_addr  = cmd_addr_q;
    assign cmd.cmd_len   = AXI_LEN;
    assign busy          = (state_q != S_IDLE);
    assign fill          = fill_q;
    assign overflow      = overflow_q;
    assign error         = error_q;

endmodule
